muxn_rr: RTL
============

# muxn_rr

Parametrised N-way, WIDTH-bit multiplexer with per-channel valid/ready handshakes, built-in arbitration and a registered output stage. It is the next generation of the 2-way combinational mux and sits wherever several producers share one datapath, for example writeback sources, memory-port requestors or debug taps. Selection is made internally by round-robin or fixed-priority arbitration instead of an external select line. Throughput is one transfer per cycle and latency is one cycle.

## Interface
- WIDTH, default 8: data width per channel, ≥1.
- N, default 4: number of input channels, ≥2. N need not be a power of two.
- RR, default 1: 1 selects round-robin arbitration, 0 selects fixed priority (lowest index wins).
- clk, input, 1: single clock; all state updates on the rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- in_valid, input, N: bit i set means channel i presents data.
- in_ready, output, N: bit i set means channel i is accepted this cycle.
- in_data, input, N*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
- out_valid, output, 1: output register holds data.
- out_ready, input, 1: consumer accepts out_data this cycle.
- out_data, output, WIDTH: registered selected data.
- out_sel, output, max(1,$clog2(N)): index of the channel that produced out_data.

## Operation
- load_en = !out_valid || out_ready. This is combinational; the stage accepts when empty or when draining in the same cycle.
- Arbitration:
  - A grant is issued only when load_en=1 and at least one in_valid bit is set.
  - in_ready is one-hot at the granted index and all-zero otherwise.
  - in_ready never asserts on a channel whose in_valid is low.
- RR=1:
  - Pointer ptr, range 0..N-1, names the highest-priority channel.
  - The search runs ptr, ptr+1, …, N-1, 0, …, ptr-1, and the first valid channel wins.
  - On a grant g, ptr <= (g+1) mod N. The wrap must be correct for non-power-of-two N, e.g. N=3, g=2 gives ptr=0.
  - With no grant, ptr holds.
- RR=0: the lowest-indexed valid channel wins. No pointer state exists, or it is held at 0.
- On a grant g: out_data <= in_data[g], out_sel <= g, out_valid <= 1.
- When load_en=1 and there is no grant, out_valid <= 0; out_data and out_sel hold their values.
- When out_valid=1 and out_ready=0, the output register and ptr hold and all in_ready bits are 0 (backpressure).
- Simultaneous drain and load: when out_valid=1, out_ready=1 and a channel is valid, the old word leaves and the new word loads in the same edge. There is no bubble.
- Reset (reset_n low, at any time, including mid-transfer):
  - Immediately, without waiting for a clock edge: out_valid=0, out_data=0, out_sel=0, ptr=0.
  - An in-flight word is discarded.
  - While reset_n is low, in_ready=0.
- Input contract: a producer holds in_valid and in_data stable until it is accepted. The block does not depend on this, but the bench checks it.

## Timing
- Latency: a word accepted at edge k appears on out_data with out_valid=1 after edge k, i.e. in cycle k+1.
- in_ready depends combinationally on in_valid, out_valid, out_ready and ptr. There is no combinational path from in_data to any output.
- Sustained throughput is 1 word/cycle while out_ready=1 and any channel is valid.
- Fairness: under RR=1 with all N channels continuously valid, each channel is granted exactly once per N consecutive grants.
- Arbitration is single-cycle; no multi-cycle locks.

## Test plan
- Reset and idle, N=4, WIDTH=8:
  - Assert reset_n=0 mid-cycle with out_valid=1 -> out_valid=0, out_data=0x00 and out_sel=0 immediately, with no clock edge.
  - After release with in_valid=0 -> in_ready=0000 and out_valid stays 0.
- Round-robin, all channels valid, data 0xA0..0xA3, out_ready=1, RR=1:
  - Grants run 0,1,2,3,0,… on successive cycles.
  - out_data runs 0xA0,0xA1,0xA2,0xA3,0xA0, one per cycle starting the cycle after the first grant.
- Backpressure: out_valid=1 holding 0x11 (sel 1), out_ready=0 for 3 cycles, in_valid=1111:
  - in_ready=0000 throughout.
  - out_data stays 0x11 and out_sel stays 1.
  - On the first out_ready=1 cycle, in_ready=0100 and the next word loads with no bubble.
- Non-power-of-two wrap, N=3, in_valid=100 then 101:
  - Grant 2 first, then ptr=0.
  - The next grant is channel 0 and out_sel=0.
- Fixed priority, RR=0, in_valid=0110 for 4 cycles with out_ready=1:
  - Channel 1 is granted every cycle and channel 2 is starved.
  - Dropping in_valid to 0100 gives grant 2.
- Drain with no new data: out_valid=1, out_ready=1, in_valid=0000 -> out_valid=0 next cycle and out_data retains its value.

Source files
------------

// File: rtl/muxn_rr.sv
// N-way valid/ready multiplexer with internal round-robin or fixed-priority
// arbitration feeding a single registered output stage (one-cycle latency).
module muxn_rr #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter bit RR    = 1'b1,
  localparam int SW   = (N > 2) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SW-1:0]        out_sel
);

  localparam logic [SW:0]   N_EXT = (SW+1)'(N);
  localparam logic [SW-1:0] LAST  = SW'(N - 1);

  logic             load_en;
  logic             grant_any;
  logic [SW-1:0]    grant_idx;
  logic [SW:0]      cand;
  logic [SW-1:0]    ptr_reg;
  logic [SW-1:0]    ptr_next;
  logic [WIDTH-1:0] sel_data;

  assign load_en = !out_valid || out_ready;

  // Search starts at ptr and wraps modulo N; with fixed priority ptr stays 0.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr_reg} + (SW+1)'(k);
      if (cand >= N_EXT) begin
        cand = cand - N_EXT;
      end
      if (!grant_any && in_valid[cand[SW-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[SW-1:0];
      end
    end
    if (!(reset_n && load_en)) begin
      grant_any = 1'b0;
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_ready
    assign in_ready[gi] = grant_any && (grant_idx == SW'(gi));
  end

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N; k++) begin
      if (grant_idx == SW'(k)) begin
        sel_data = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign ptr_next = (grant_idx == LAST) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr_reg   <= '0;
    end else if (load_en) begin
      if (grant_any) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_sel   <= grant_idx;
        if (RR) begin
          ptr_reg <= ptr_next;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
